dec_rr_arbiter: RTL and testbench
=================================

DEC_RR_ARBITER -- requirements
Module: dec_rr_arbiter

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, giving the requester index width.
REQ-002 The block SHALL have parameter N, default 2**IDX_W (16), giving the requester count; N is derived and SHALL NOT be overridden independently.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum grant length in cycles; legal range is 1..255.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N bits: one request line per requester, level-sensitive.
REQ-007 The block SHALL have port release, input, 1 bit: the current owner ends its grant.
REQ-008 The block SHALL have port grant, output, N bits: one-hot grant, equal to (1 << grant_idx) when grant_valid=1, else all zero.
REQ-009 The block SHALL have port grant_idx, output, IDX_W bits: binary index of the current owner; 0 when grant_valid=0.
REQ-010 The block SHALL have port grant_valid, output, 1 bit: a grant is active.
REQ-011 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 All outputs SHALL be registered; there SHALL be no combinational path from req or release to any output.
REQ-013 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-014 The block SHALL hold an IDX_W-bit priority pointer ptr, naming the requester with the highest priority.
REQ-015 In IDLE, at a rising edge with |req=1, the block SHALL select the first set bit of req scanning upward from ptr with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
REQ-016 On that edge the block SHALL load grant_idx with the selected index, set grant_valid=1, drive grant with the decoded one-hot value, clear hold_cnt to 0, and enter GRANT.
REQ-017 Grant latency SHALL be one edge: a req bit first seen high at edge k in IDLE produces grant_valid=1 immediately after edge k.
REQ-018 In IDLE with req=0, the block SHALL keep all outputs at zero and leave ptr unchanged.
REQ-019 In GRANT, the grant SHALL end at the edge where any of these hold: release=1; req[grant_idx]=0; hold_cnt==MAX_HOLD-1.
REQ-020 At a grant-ending edge, the block SHALL clear grant, grant_idx and grant_valid to 0, set ptr to grant_idx+1 modulo N (15 wraps to 0), and enter IDLE.
REQ-021 Ending grants SHALL leave exactly one IDLE cycle between consecutive grants; back-to-back grants without a bubble are not permitted.
REQ-022 In GRANT, when no end condition holds, hold_cnt SHALL increment by 1 and all grant outputs SHALL stay stable.
REQ-023 hold_cnt SHALL be 8 bits wide and SHALL never exceed MAX_HOLD-1.
REQ-024 A grant SHALL therefore last at most MAX_HOLD cycles; with MAX_HOLD=1, every grant lasts exactly one cycle.
REQ-025 timeout SHALL be 1 for exactly the cycle following an ending edge where hold_cnt==MAX_HOLD-1, release=0 and req[grant_idx]=1.
REQ-026 If release or a dropped request coincides with the hold limit, timeout SHALL stay 0.
REQ-027 Changes to req bits other than grant_idx during GRANT SHALL have no effect until the next IDLE cycle.
REQ-028 release asserted in IDLE SHALL be ignored.
REQ-029 Fairness: a requester held continuously high SHALL be granted within N grants.

Reset
REQ-030 When reset=1 at a rising edge, the block SHALL enter IDLE and clear ptr to 0, hold_cnt to 0, and grant, grant_idx, grant_valid and timeout to 0.
REQ-031 Reset SHALL take priority over every other condition, including in mid-grant, and SHALL produce no timeout pulse.
REQ-032 On the first edge after reset deasserts, the block SHALL arbitrate from ptr=0.

Verification
REQ-033 The bench SHALL check: after reset, req=16'h0009 held -> grant=16'h0001, idx=0 for 8 cycles, timeout pulse, 1 idle cycle, then grant=16'h0008, idx=3.
REQ-034 The bench SHALL check: wrap-around, grant to idx 15 ends, req=16'h8001 -> next grant idx 0 (ptr wrapped to 0).
REQ-035 The bench SHALL check: release pulsed on the 3rd grant cycle -> grant drops after that edge, timeout=0, ptr=idx+1.
REQ-036 The bench SHALL check: the owner's req drops at the same edge hold_cnt reaches 7 -> grant ends, timeout=0.
REQ-037 The bench SHALL check: reset asserted mid-grant with req=16'h0010 -> all outputs 0, then a grant to idx 4 via scan from ptr 0, with no timeout.
REQ-038 The bench SHALL check: all 16 requests held high for 16 grants -> indices granted in order 0..15, each for exactly 8 cycles.

Source files
------------

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter with a bounded hold time.
//
// A two-state FSM (IDLE / GRANT) hands a single grant to one of N requesters.
// In IDLE the first active request at or above the priority pointer (with wrap)
// wins. The winner keeps the grant until it releases, drops its request, or
// reaches MAX_HOLD cycles; the pointer then moves to the owner's index + 1,
// and at least one IDLE cycle separates consecutive grants.
//
// Parameters
//   IDX_W     requester index width
//   MAX_HOLD  maximum grant length in cycles (1..255)
//   N         requester count, fixed at 2**IDX_W
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   req[N]       level-sensitive request lines
//   rel          owner ends its grant ('release' is a reserved word in SV)
//   grant[N]     one-hot grant (registered)
//   grant_idx    binary index of the owner, 0 when idle (registered)
//   grant_valid  a grant is active (registered)
//   timeout      one-cycle pulse after a grant is revoked by the hold limit
module dec_rr_arbiter #(
  parameter  int IDX_W    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int N        = 2**IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [7:0]       hold_cnt, hold_nx;
  logic [N-1:0]     grant_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             valid_nx, timeout_nx;

  logic [IDX_W-1:0] pick, cand;
  logic             pick_ok;
  logic             at_limit, owner_req, grant_end;

  // Rotating scan: candidate index wraps naturally in IDX_W bits.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  assign at_limit  = (hold_cnt == HOLD_LAST);
  assign owner_req = req[grant_idx];
  assign grant_end = rel || !owner_req || at_limit;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    grant_nx   = grant;
    idx_nx     = grant_idx;
    valid_nx   = grant_valid;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = '0;
        idx_nx   = '0;
        valid_nx = 1'b0;
        if (pick_ok) begin
          state_nx = GRANT;
          idx_nx   = pick;
          grant_nx = N'(1) << pick;
          valid_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_nx   = IDLE;
          grant_nx   = '0;
          idx_nx     = '0;
          valid_nx   = 1'b0;
          hold_nx    = '0;
          ptr_nx     = grant_idx + IDX_W'(1);
          // Only a pure hold-limit revocation counts as a timeout.
          timeout_nx = at_limit && !rel && owner_req;
        end else begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hold_cnt    <= hold_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Testbench for dec_rr_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_dec_rr_arbiter;

  localparam int MAXH = 8;

  logic        clock;
  logic        reset;
  logic [15:0] req;
  logic        rel;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  // Model state: owner (-1 = none), priority pointer, cycles owner has held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 0;

  dec_rr_arbiter #(.IDX_W(4), .MAX_HOLD(MAXH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [15:0] rq, input logic rl, input logic rs);
    int  c;
    bit  limit;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_tmo = 0;
    end else if (m_owner < 0) begin
      m_tmo = 0;
      for (int k = 0; k < 16; k++) begin
        c = (m_ptr + k) % 16;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c;
          m_held  = 1;
        end
      end
    end else begin
      limit = (m_held == MAXH);
      if (rl || !rq[m_owner] || limit) begin
        m_tmo   = limit && !rl && rq[m_owner];
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end else begin
        m_tmo = 0;
        m_held++;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic [15:0] rq, input logic rl, input logic rs);
    logic [15:0] eg;
    req = rq; rel = rl; reset = rs;
    @(posedge clock);
    model(rq, rl, rs);
    #1;
    eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    check("grant", grant, eg);
    check("grant_idx", grant_idx, (m_owner >= 0) ? m_owner : 0);
    check("grant_valid", grant_valid, m_owner >= 0);
    check("timeout", timeout, m_tmo);
  endtask

  logic [15:0] rq_r;

  initial begin
    req = '0; rel = 1'b0; reset = 1'b1;

    // Reset state
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b1);
    check("rst_valid", grant_valid, 0);
    check("rst_grant", grant, 0);

    // req=0009 held: idx 0 for 8 cycles, timeout, bubble, then idx 3
    for (int c = 0; c < 8; c++) begin
      step(16'h0009, 1'b0, 1'b0);
      check("hold0_grant", grant, 16'h0001);
    end
    step(16'h0009, 1'b0, 1'b0);
    check("hold0_tmo", timeout, 1);
    check("hold0_bubble", grant_valid, 0);
    step(16'h0009, 1'b0, 1'b0);
    check("next3_grant", grant, 16'h0008);
    check("next3_idx", grant_idx, 3);
    check("next3_tmo", timeout, 0);

    // Wrap-around: grant to 15 ends by release, then 8001 -> idx 0
    step(16'h0000, 1'b0, 1'b1);
    step(16'h8000, 1'b0, 1'b0);
    check("wrap_idx15", grant_idx, 15);
    step(16'h8001, 1'b0, 1'b0);
    step(16'h8001, 1'b1, 1'b0);
    check("wrap_end", grant_valid, 0);
    step(16'h8001, 1'b0, 1'b0);
    check("wrap_idx0", grant_idx, 0);

    // Release during the 3rd grant cycle
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0024, 1'b0, 1'b0);
    step(16'h0024, 1'b0, 1'b0);
    step(16'h0024, 1'b0, 1'b0);
    check("rel_pre", grant_idx, 2);
    step(16'h0024, 1'b1, 1'b0);
    check("rel_drop", grant_valid, 0);
    check("rel_tmo", timeout, 0);
    step(16'h0024, 1'b0, 1'b0);
    check("rel_ptr_idx5", grant_idx, 5);

    // Owner drops request exactly at hold limit
    step(16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) step(16'h0002, 1'b0, 1'b0);
    check("drop_pre", grant_idx, 1);
    step(16'h0000, 1'b0, 1'b0);
    check("drop_end", grant_valid, 0);
    check("drop_tmo", timeout, 0);
    // Release coinciding with hold limit
    for (int c = 0; c < 8; c++) step(16'h0002, 1'b0, 1'b0);
    step(16'h0002, 1'b1, 1'b0);
    check("rel_lim_tmo", timeout, 0);

    // Reset mid-grant, then scan restarts from ptr 0
    step(16'h0010, 1'b0, 1'b0);
    step(16'h0010, 1'b0, 1'b0);
    check("mid_pre", grant_idx, 4);
    step(16'h0010, 1'b0, 1'b1);
    check("mid_rst_valid", grant_valid, 0);
    check("mid_rst_tmo", timeout, 0);
    step(16'h0110, 1'b0, 1'b0);
    check("mid_idx4", grant_idx, 4);
    check("mid_no_tmo", timeout, 0);

    // All 16 requesting: 0..15 in order, 8 cycles each
    step(16'h0000, 1'b0, 1'b1);
    for (int g = 0; g < 16; g++) begin
      for (int c = 0; c < 8; c++) begin
        step(16'hFFFF, 1'b0, 1'b0);
        check("rr_idx", grant_idx, g);
      end
      step(16'hFFFF, 1'b0, 1'b0);
      check("rr_tmo", timeout, 1);
    end

    // Randomized traffic
    rq_r = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0)
        rq_r = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                           : 16'($urandom & $urandom & $urandom);
      step(rq_r, ($urandom_range(0, 11) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
